move_scheduler: RTL
===================

# move_scheduler

Move queue and arbiter in front of the stepper driver. Accepts face-turn codes from two requesters: the state-determination setup path (A) and the solving algorithm (B). Buffers them in a FIFO and issues them one at a time to the stepper driver using the start/done handshake. Enforces a settle gap after each move so the color sensors and mechanics are stable before the next turn.

## Interface
Parameters:
- DEPTH, 16: FIFO entries; power of 2, minimum 4.
- SETTLE_CYCLES, 25000: idle clocks after move_done before the next issue (1 ms at 25 MHz); minimum 1.

Ports:
- clock_25mhz  in  1  system clock.
- reset  in  1  synchronous, active-high; clock clock_25mhz.
- a_valid  in  1  requester A (setup moves) presents a move.
- a_move  in  4  requester A move code.
- a_ready  out  1  A accepted this cycle.
- b_valid  in  1  requester B (solver) presents a move.
- b_move  in  4  requester B move code.
- b_ready  out  1  B accepted this cycle.
- flush  in  1  discard all queued, un-issued moves.
- next_move  out  4  move code to stepper driver.
- move_start  out  1  one-cycle issue pulse.
- move_done  in  1  stepper driver completion pulse.
- count  out  $clog2(DEPTH)+1  queued entries.
- idle  out  1  FIFO empty and FSM in IDLE.
- issued_count  out  8  moves issued since reset; saturates at 255.
- invalid_move  out  1  one-cycle pulse when an accepted code was discarded.

## Operation
- Valid codes are 2..13 (R=2, Ri=3 … D=12, Di=13); the inverse of a code is code^1.
- Codes 0, 1, 14, and 15 are accepted (ready high), not stored, and pulse invalid_move the next cycle.
- Arbitration is fixed priority with A over B, and at most one push per cycle.
- a_ready = a_valid & !full. b_ready = b_valid & !a_valid & !full.
- When full, no requester is accepted.
- FSM states:
  - IDLE: if count != 0 and flush is not asserted, pop the head into next_move and go to ISSUE.
  - ISSUE: move_start = 1 for exactly this cycle; go to WAIT_DONE.
  - WAIT_DONE: hold next_move; on move_done, load the settle counter and go to SETTLE.
  - SETTLE: count down SETTLE_CYCLES; on reaching 0, go to IDLE.
- move_done outside WAIT_DONE is ignored. A move_done in the ISSUE cycle is ignored.
- next_move stays stable from ISSUE until the next pop.
- Simultaneous push and pop leaves count unchanged.
- flush clears the FIFO the same cycle and takes priority over a same-cycle push and pop. A push in the flush cycle is refused (ready low).
- flush does not abort an in-flight move; ISSUE, WAIT_DONE, and SETTLE complete normally.
- issued_count increments on each move_start and holds at 255.
- Reset values: FIFO empty, state IDLE, next_move 0, move_start 0, a_ready 0, b_ready 0, count 0, idle 1, issued_count 0, invalid_move 0.
- A reset asserted mid-move returns to IDLE immediately. A later move_done is then ignored.

## Timing
- A push in cycle t appears in count at t+1.
- If the FSM is idle and the FIFO was empty, the pop occurs at t+1 and move_start at t+2.
- Back-to-back moves: move_start(n+1) fires SETTLE_CYCLES+2 cycles after move_done(n).
- ready outputs are combinational from valid/full/flush. All other outputs are registered.

## Configuration
- MOVE_CANCEL_EN defined: a valid incoming move equal to the FIFO tail ^1 removes the tail instead of being pushed. Ready is high, count decrements, and nothing is issued.
  - Cancellation requires count >= 2, or count == 1 with no pop in the same cycle. Otherwise the move is pushed normally.
  - Cancelled entries are never issued and do not count toward issued_count.
- MOVE_CANCEL_EN undefined: every valid move is pushed and issued verbatim.

## Structure
- Shared package rbot_moves_pkg holds:
  - the move code localparams R..Di and MOVE_W=4;
  - an is_valid_move function;
  - an inverse_move function (code^1).
- Sub-module move_fifo: circular buffer with push, pop, flush, and drop_tail ports. It exposes head, tail, count, full, and empty. Pointers wrap modulo DEPTH, and count is tracked separately.
- The arbiter, FSM, settle counter, and statistics live in move_scheduler.

## Test plan
- Single move: with SETTLE_CYCLES=4, push A move 4 (U) at t0.
  - Expect move_start at t0+2 with next_move=4.
  - Drive move_done at t0+10; expect idle=1 at t0+15.
- Arbitration: A and B both valid with moves 2 and 6 for 3 cycles.
  - Expect only A accepted (a_ready=1, b_ready=0).
  - Expect the issue order to be 2,2,2, then B accepted once A drops.
- Full and wrap: with DEPTH=4, push 6 moves while the driver is stalled.
  - Expect ready low once count=4.
  - Expect issue order to match push order across pointer wrap after done pulses resume.
- Invalid: push codes 0 and 15 with count 0.
  - Expect ready high, invalid_move pulsed twice, count stays 0, no move_start.
- Flush and reset: flush while in WAIT_DONE with count=3.
  - Expect count=0 next cycle and the in-flight move still completing.
  - Reset mid-SETTLE returns idle=1 and issued_count=0.
- MOVE_CANCEL_EN:
  - While stalled in WAIT_DONE, queue 8 then push 9: count goes 1 to 0, and 8 is never issued.
  - Queue 8 then push 8 with the macro undefined: both issued.

Source files
------------

// File: rtl/rbot_moves_pkg.sv
// Face-turn move codes shared by the cube robot, plus validity and inverse helpers.
package rbot_moves_pkg;

    localparam int MOVE_W = 4;

    localparam logic [MOVE_W-1:0] MOVE_R  = 4'd2;
    localparam logic [MOVE_W-1:0] MOVE_RI = 4'd3;
    localparam logic [MOVE_W-1:0] MOVE_U  = 4'd4;
    localparam logic [MOVE_W-1:0] MOVE_UI = 4'd5;
    localparam logic [MOVE_W-1:0] MOVE_F  = 4'd6;
    localparam logic [MOVE_W-1:0] MOVE_FI = 4'd7;
    localparam logic [MOVE_W-1:0] MOVE_L  = 4'd8;
    localparam logic [MOVE_W-1:0] MOVE_LI = 4'd9;
    localparam logic [MOVE_W-1:0] MOVE_B  = 4'd10;
    localparam logic [MOVE_W-1:0] MOVE_BI = 4'd11;
    localparam logic [MOVE_W-1:0] MOVE_D  = 4'd12;
    localparam logic [MOVE_W-1:0] MOVE_DI = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_SETTLE
    } sched_state_e;

    function automatic logic is_valid_move(input logic [MOVE_W-1:0] code);
        return (code >= MOVE_R) && (code <= MOVE_DI);
    endfunction

    // Clockwise and counter-clockwise turns of a face differ only in bit 0.
    function automatic logic [MOVE_W-1:0] inverse_move(input logic [MOVE_W-1:0] code);
        return code ^ 4'b0001;
    endfunction

endpackage

// File: rtl/move_fifo.sv
// Circular move buffer with flush and tail-drop; pointers wrap modulo DEPTH, occupancy kept in its own counter.
module move_fifo
    import rbot_moves_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clock_25mhz,
    input  logic                     reset,
    input  logic                     push,
    input  logic [MOVE_W-1:0]        push_data,
    input  logic                     pop,
    input  logic                     flush,
    input  logic                     drop_tail,
    output logic [MOVE_W-1:0]        head,
    output logic [MOVE_W-1:0]        tail,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [MOVE_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  tail_ptr;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop, do_drop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign tail_ptr = wr_ptr_q - 1'b1;
    assign head     = mem_q[rd_ptr_q];
    assign tail     = mem_q[tail_ptr];

    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    // A drop never races a push, and never removes the entry a same-cycle pop takes.
    assign do_drop = drop_tail & ~flush & ~do_push & (count_q > {{PTR_W{1'b0}}, do_pop});

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end else if (do_drop) begin
                wr_ptr_d = tail_ptr;
            end
            count_d = count_q + {{PTR_W{1'b0}}, do_push}
                              - {{PTR_W{1'b0}}, do_pop}
                              - {{PTR_W{1'b0}}, do_drop};
        end
    end

    always_ff @(posedge clock_25mhz) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock_25mhz) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/move_scheduler.sv
// Two-requester move queue and stepper issue FSM with a post-move settle gap.
// Define MOVE_CANCEL_EN to let an incoming inverse move annihilate the queued tail.
module move_scheduler
    import rbot_moves_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int SETTLE_CYCLES = 25000
) (
    input  logic                     clock_25mhz,
    input  logic                     reset,
    input  logic                     a_valid,
    input  logic [MOVE_W-1:0]        a_move,
    output logic                     a_ready,
    input  logic                     b_valid,
    input  logic [MOVE_W-1:0]        b_move,
    output logic                     b_ready,
    input  logic                     flush,
    output logic [MOVE_W-1:0]        next_move,
    output logic                     move_start,
    input  logic                     move_done,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     idle,
    output logic [7:0]               issued_count,
    output logic                     invalid_move
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("move_scheduler: DEPTH must be a power of two and at least 4");
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("move_scheduler: SETTLE_CYCLES must be at least 1");
    end

    logic              fifo_full, fifo_empty;
    logic [MOVE_W-1:0] fifo_head, fifo_tail;
    logic [CNT_W-1:0]  fifo_count;
    logic              accept, code_ok, do_push, do_pop, do_cancel;
    logic [MOVE_W-1:0] acc_move;

    sched_state_e      state_q, state_d;
    logic [MOVE_W-1:0] next_move_q, next_move_d;
    logic              move_start_q, move_start_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic [7:0]        issued_q, issued_d;
    logic              invalid_q, invalid_d;

    // Fixed priority: A wins, B only when A is silent; nothing is taken while flushing.
    assign a_ready  = a_valid & ~fifo_full & ~flush & ~reset;
    assign b_ready  = b_valid & ~a_valid & ~fifo_full & ~flush & ~reset;
    assign accept   = a_ready | b_ready;
    assign acc_move = a_ready ? a_move : b_move;
    assign code_ok  = is_valid_move(acc_move);
    assign do_pop   = (state_q == ST_IDLE) & ~fifo_empty & ~flush;

`ifdef MOVE_CANCEL_EN
    // The tail is only removable if a same-cycle pop is not about to take it.
    assign do_cancel = accept & code_ok
                     & (acc_move == inverse_move(fifo_tail))
                     & ((fifo_count >= CNT_W'(2)) | ((fifo_count == CNT_W'(1)) & ~do_pop));
`else
    logic [MOVE_W-1:0] unused_tail;
    assign unused_tail = fifo_tail;
    assign do_cancel   = 1'b0;
`endif

    assign do_push   = accept & code_ok & ~do_cancel;
    assign invalid_d = accept & ~code_ok;

    move_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock_25mhz(clock_25mhz),
        .reset      (reset),
        .push       (do_push),
        .push_data  (acc_move),
        .pop        (do_pop),
        .flush      (flush),
        .drop_tail  (do_cancel),
        .head       (fifo_head),
        .tail       (fifo_tail),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        next_move_d  = next_move_q;
        move_start_d = 1'b0;
        settle_d     = settle_q;
        issued_d     = issued_q;
        if (move_start_q && issued_q != 8'hFF) begin
            issued_d = issued_q + 8'd1;
        end
        case (state_q)
            ST_IDLE: begin
                if (do_pop) begin
                    next_move_d  = fifo_head;
                    move_start_d = 1'b1;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (move_done) begin
                    settle_d = SET_W'(SETTLE_CYCLES);
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                settle_d = settle_q - 1'b1;
                if (settle_q <= SET_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_25mhz) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            next_move_q  <= '0;
            move_start_q <= 1'b0;
            settle_q     <= '0;
            issued_q     <= '0;
            invalid_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            next_move_q  <= next_move_d;
            move_start_q <= move_start_d;
            settle_q     <= settle_d;
            issued_q     <= issued_d;
            invalid_q    <= invalid_d;
        end
    end

    assign next_move    = next_move_q;
    assign move_start   = move_start_q;
    assign count        = fifo_count;
    assign idle         = (state_q == ST_IDLE) & fifo_empty;
    assign issued_count = issued_q;
    assign invalid_move = invalid_q;

endmodule
